// File: rtl/tensor_core_pkg.sv
// tensor_core_pkg: shared types and helpers for the tensor-core MMA engine.
//   tc_state_t  : engine state encoding (IDLE, COMPUTE, DONE)
//   clog2       : ceiling log2 for elaboration-time sizing
//   acc_width   : full-precision accumulator width for a DIM-term dot product
//   fits        : 1 when an accumulator value is representable in dw bits
//   reduce_elem : accumulator -> result element; saturates when
//                 TENSOR_CORE_SATURATE_EN is defined, otherwise wraps
package tensor_core_pkg;

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} tc_state_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r = r + 1;
    return r;
  endfunction

  // Products need 2*dw bits, summing dim of them plus the addend needs
  // clog2(dim)+1 more.
  function automatic int unsigned acc_width(input int unsigned dw, input int unsigned dim);
    return 2 * dw + clog2(dim) + 1;
  endfunction

  function automatic bit fits(input longint acc, input int unsigned dw);
    longint hi;
    longint lo;
    hi = (longint'(1) <<< (dw - 1)) - 1;
    lo = -hi - 1;
    return (acc <= hi) && (acc >= lo);
  endfunction

  // Caller keeps the low dw bits of the returned value.
  function automatic longint reduce_elem(input longint acc, input int unsigned dw);
    longint hi;
    longint lo;
    hi = (longint'(1) <<< (dw - 1)) - 1;
    lo = -hi - 1;
`ifdef TENSOR_CORE_SATURATE_EN
    if (acc > hi) return hi;
    if (acc < lo) return lo;
    return acc;
`else
    return acc & ((longint'(1) <<< dw) - 1);
`endif
  endfunction

endpackage

// File: rtl/tensor_core_mma_engine_dot_lane.sv
// tensor_core_dot_lane: combinational DIM-term signed dot product with
// optional sign-extended addend, computed at full ACC_WIDTH precision.
//   a_row  : row of A (DIM signed elements)
//   b_col  : column of B (DIM signed elements)
//   addend : C element, added when add_en is high
//   dot    : sum(a_row[k]*b_col[k]) (+ addend)
module tensor_core_dot_lane
  import tensor_core_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DIM        = 4,
  parameter int unsigned ACC_WIDTH  = acc_width(DATA_WIDTH, DIM)
) (
  input  logic signed [DATA_WIDTH-1:0] a_row [DIM],
  input  logic signed [DATA_WIDTH-1:0] b_col [DIM],
  input  logic signed [DATA_WIDTH-1:0] addend,
  input  logic                         add_en,
  output logic signed [ACC_WIDTH-1:0]  dot
);

  logic signed [ACC_WIDTH-1:0] a_ext;
  logic signed [ACC_WIDTH-1:0] b_ext;

  always_comb begin
    a_ext = '0;
    b_ext = '0;
    dot   = add_en ? ACC_WIDTH'(addend) : '0;
    for (int unsigned k = 0; k < DIM; k++) begin
      a_ext = ACC_WIDTH'(a_row[k]);
      b_ext = ACC_WIDTH'(b_col[k]);
      dot   = dot + a_ext * b_ext;
    end
  end

endmodule

// File: rtl/tensor_core_mma_engine.sv
// tensor_core_mma_engine: sequential DIM x DIM signed matrix multiply
// (D = A*B, or D = A*B + C when accumulate is latched), LANES output
// elements per cycle in row-major order. Optional macro
// TENSOR_CORE_SATURATE_EN selects clamping instead of wrapping.
//   clock_in / reset_in           : clock, synchronous active-high reset
//   start_in / accumulate_in      : start request, accumulate mode
//   tensor_core_input1/2/3        : A, B, C operand matrices
//   tensor_core_output            : registered result D
//   busy_out                      : high while computing
//   is_done_with_calculation      : high while results are final
//   overflow_out                  : sticky out-of-range flag for this result
module tensor_core_mma_engine
  import tensor_core_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DIM        = 4,
  parameter int unsigned LANES      = 4
) (
  input  logic                  clock_in,
  input  logic                  reset_in,
  input  logic                  start_in,
  input  logic                  accumulate_in,
  input  logic [DATA_WIDTH-1:0] tensor_core_input1 [DIM][DIM],
  input  logic [DATA_WIDTH-1:0] tensor_core_input2 [DIM][DIM],
  input  logic [DATA_WIDTH-1:0] tensor_core_input3 [DIM][DIM],
  output logic [DATA_WIDTH-1:0] tensor_core_output [DIM][DIM],
  output logic                  busy_out,
  output logic                  is_done_with_calculation,
  output logic                  overflow_out
);

  localparam int unsigned ACC_WIDTH = acc_width(DATA_WIDTH, DIM);
  localparam int unsigned NUM_ELEM  = DIM * DIM;
  localparam int unsigned IDX_W     = clog2(NUM_ELEM) + 1;
  localparam int unsigned RC_W      = (clog2(DIM) > 0) ? clog2(DIM) : 1;
  localparam int unsigned LAST_IDX  = NUM_ELEM - LANES;

  if ((NUM_ELEM % LANES) != 0) begin : g_lanes_check
    $error("tensor_core_mma_engine: LANES must divide DIM*DIM");
  end

  tc_state_t                   state;
  logic [IDX_W-1:0]            index;
  logic                        op_acc;
  logic signed [DATA_WIDTH-1:0] op_a [DIM][DIM];
  logic signed [DATA_WIDTH-1:0] op_b [DIM][DIM];
  logic signed [DATA_WIDTH-1:0] op_c [DIM][DIM];

  logic [RC_W-1:0]              lane_row [LANES];
  logic [RC_W-1:0]              lane_col [LANES];
  logic signed [DATA_WIDTH-1:0] lane_a   [LANES][DIM];
  logic signed [DATA_WIDTH-1:0] lane_b   [LANES][DIM];
  logic signed [ACC_WIDTH-1:0]  lane_sum [LANES];
  logic [DATA_WIDTH-1:0]        lane_val [LANES];
  logic [LANES-1:0]             lane_ovf;

  // Operand routing: each lane gets the A row and B column of its element.
  always_comb begin
    logic [IDX_W-1:0] e;
    e = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      e           = index + IDX_W'(l);
      lane_row[l] = RC_W'(e / IDX_W'(DIM));
      lane_col[l] = RC_W'(e % IDX_W'(DIM));
      for (int unsigned k = 0; k < DIM; k++) begin
        lane_a[l][k] = op_a[lane_row[l]][k];
        lane_b[l][k] = op_b[k][lane_col[l]];
      end
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    tensor_core_dot_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .DIM        (DIM),
      .ACC_WIDTH  (ACC_WIDTH)
    ) u_dot_lane (
      .a_row  (lane_a[l]),
      .b_col  (lane_b[l]),
      .addend (op_c[lane_row[l]][lane_col[l]]),
      .add_en (op_acc),
      .dot    (lane_sum[l])
    );
  end

  always_comb begin
    for (int unsigned l = 0; l < LANES; l++) begin
      lane_val[l] = DATA_WIDTH'(reduce_elem(longint'(lane_sum[l]), DATA_WIDTH));
      lane_ovf[l] = !fits(longint'(lane_sum[l]), DATA_WIDTH);
    end
  end

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state                    <= IDLE;
      index                    <= '0;
      busy_out                 <= 1'b0;
      is_done_with_calculation <= 1'b0;
      overflow_out             <= 1'b0;
      for (int unsigned i = 0; i < DIM; i++)
        for (int unsigned j = 0; j < DIM; j++)
          tensor_core_output[i][j] <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start_in) begin
            op_acc <= accumulate_in;
            for (int unsigned i = 0; i < DIM; i++)
              for (int unsigned j = 0; j < DIM; j++) begin
                op_a[i][j]               <= tensor_core_input1[i][j];
                op_b[i][j]               <= tensor_core_input2[i][j];
                op_c[i][j]               <= tensor_core_input3[i][j];
                tensor_core_output[i][j] <= '0;
              end
            index                    <= '0;
            overflow_out             <= 1'b0;
            is_done_with_calculation <= 1'b0;
            busy_out                 <= 1'b1;
            state                    <= COMPUTE;
          end
        end
        COMPUTE: begin
          for (int unsigned l = 0; l < LANES; l++)
            tensor_core_output[lane_row[l]][lane_col[l]] <= lane_val[l];
          if (|lane_ovf) overflow_out <= 1'b1;
          if (index == IDX_W'(LAST_IDX)) begin
            state                    <= DONE;
            is_done_with_calculation <= 1'b1;
            busy_out                 <= 1'b0;
          end else begin
            index <= index + IDX_W'(LANES);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tensor_core_mma_engine.sv
module tb_tensor_core_mma_engine;

  logic       clock_in = 1'b0;
  logic       reset_in;
  logic       start_in;
  logic       accumulate_in;
  logic [7:0] a_m [4][4];
  logic [7:0] b_m [4][4];
  logic [7:0] c_m [4][4];
  logic [7:0] d4  [4][4];
  logic [7:0] d1  [4][4];
  logic [7:0] d16 [4][4];
  logic       busy4, done4, ovf4;
  logic       busy1, done1, ovf1;
  logic       busy16, done16, ovf16;

  logic [7:0] exp_d [4][4];
  logic       exp_ovf;
  int         tests = 0;
  int         fails = 0;
  int         edges;
  int         busy_cycles;

  always #5 clock_in = ~clock_in;

  tensor_core_mma_engine #(.DATA_WIDTH(8), .DIM(4), .LANES(4)) dut (
    .clock_in (clock_in), .reset_in (reset_in), .start_in (start_in),
    .accumulate_in (accumulate_in),
    .tensor_core_input1 (a_m), .tensor_core_input2 (b_m), .tensor_core_input3 (c_m),
    .tensor_core_output (d4), .busy_out (busy4),
    .is_done_with_calculation (done4), .overflow_out (ovf4)
  );

  tensor_core_mma_engine #(.DATA_WIDTH(8), .DIM(4), .LANES(1)) dut_l1 (
    .clock_in (clock_in), .reset_in (reset_in), .start_in (start_in),
    .accumulate_in (accumulate_in),
    .tensor_core_input1 (a_m), .tensor_core_input2 (b_m), .tensor_core_input3 (c_m),
    .tensor_core_output (d1), .busy_out (busy1),
    .is_done_with_calculation (done1), .overflow_out (ovf1)
  );

  tensor_core_mma_engine #(.DATA_WIDTH(8), .DIM(4), .LANES(16)) dut_l16 (
    .clock_in (clock_in), .reset_in (reset_in), .start_in (start_in),
    .accumulate_in (accumulate_in),
    .tensor_core_input1 (a_m), .tensor_core_input2 (b_m), .tensor_core_input3 (c_m),
    .tensor_core_output (d16), .busy_out (busy16),
    .is_done_with_calculation (done16), .overflow_out (ovf16)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, expv);
    end
  endtask

  task automatic check_mat(input string tag, input logic [7:0] m [4][4]);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        check($sformatf("%s[%0d][%0d]", tag, i, j), 32'(m[i][j]), 32'(exp_d[i][j]));
  endtask

  task automatic fill(input logic [7:0] av, input logic [7:0] bv, input logic [7:0] cv);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        a_m[i][j] = av;
        b_m[i][j] = bv;
        c_m[i][j] = cv;
      end
  endtask

  task automatic fill_exp(input logic [7:0] v);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) exp_d[i][j] = v;
  endtask

  // Independent reference: full-precision sums, then clamp or wrap.
  task automatic model();
    longint s;
    exp_ovf = 1'b0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        s = accumulate_in ? longint'($signed(c_m[i][j])) : 0;
        for (int k = 0; k < 4; k++)
          s = s + longint'($signed(a_m[i][k])) * longint'($signed(b_m[k][j]));
        if (s > 127 || s < -128) exp_ovf = 1'b1;
`ifdef TENSOR_CORE_SATURATE_EN
        if (s > 127) s = 127;
        else if (s < -128) s = -128;
`endif
        exp_d[i][j] = s[7:0];
      end
  endtask

  // Edge E0: start sampled.
  task automatic start_run();
    @(negedge clock_in);
    start_in = 1'b1;
    @(posedge clock_in);
    #1;
    start_in = 1'b0;
  endtask

  // Continues counting edges (E0 = 1) until done or budget expires.
  task automatic wait_done(input int start_edges, output int n_edges, output int n_busy);
    n_edges = start_edges;
    n_busy  = busy4 ? 1 : 0;
    while (!done4 && n_edges < 64) begin
      @(posedge clock_in);
      #1;
      n_edges++;
      if (busy4) n_busy++;
    end
  endtask

  initial begin
    int e4, e1, e16;
    reset_in      = 1'b1;
    start_in      = 1'b0;
    accumulate_in = 1'b0;
    fill(8'd0, 8'd0, 8'd0);
    repeat (2) @(posedge clock_in);
    #1;
    check("rst_busy", 32'(busy4), 0);
    check("rst_done", 32'(done4), 0);
    check("rst_ovf", 32'(ovf4), 0);
    fill_exp(8'd0);
    check_mat("rst_d", d4);
    @(negedge clock_in);
    reset_in = 1'b0;

    // Identity * B = B
    fill(8'd0, 8'd0, 8'd0);
    for (int i = 0; i < 4; i++) begin
      a_m[i][i] = 8'd1;
      for (int j = 0; j < 4; j++) b_m[i][j] = 8'(4 * i + j);
    end
    start_run();
    check("e0_busy", 32'(busy4), 1);
    check("e0_done", 32'(done4), 0);
    fill(8'd0, 8'd0, 8'd0);  // operands must already be latched
    wait_done(1, edges, busy_cycles);
    check("id_latency", 32'(edges), 5);
    check("id_busy_cycles", 32'(busy_cycles), 4);
    check("id_ovf", 32'(ovf4), 0);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) exp_d[i][j] = 8'(4 * i + j);
    check_mat("id_d", d4);

    // Accumulate: 4*1*2 + 3 = 11 ; started from DONE
    fill(8'd1, 8'd2, 8'd3);
    accumulate_in = 1'b1;
    start_run();
    check("acc_done_drop", 32'(done4), 0);
    wait_done(1, edges, busy_cycles);
    check("acc_latency", 32'(edges), 5);
    fill_exp(8'd11);
    check_mat("acc_d", d4);

    accumulate_in = 1'b0;
    start_run();
    wait_done(1, edges, busy_cycles);
    fill_exp(8'd8);
    check_mat("noacc_d", d4);
    check("noacc_ovf", 32'(ovf4), 0);

    // 127*127*4 = 64516
    fill(8'd127, 8'd127, 8'd0);
    start_run();
    wait_done(1, edges, busy_cycles);
`ifdef TENSOR_CORE_SATURATE_EN
    fill_exp(8'd127);
`else
    fill_exp(8'd4);
`endif
    check_mat("pos_ovf_d", d4);
    check("pos_ovf_flag", 32'(ovf4), 1);

    // -128*127*4 = -65024
    fill(8'h80, 8'd127, 8'd0);
    start_run();
    wait_done(1, edges, busy_cycles);
`ifdef TENSOR_CORE_SATURATE_EN
    fill_exp(8'h80);
`else
    fill_exp(8'd0);
`endif
    check_mat("neg_ovf_d", d4);
    check("neg_ovf_flag", 32'(ovf4), 1);

    // Start during COMPUTE ignored; overflow cleared by the new start
    fill(8'd1, 8'd2, 8'd3);
    accumulate_in = 1'b1;
    start_run();
    @(posedge clock_in);
    #1;
    @(negedge clock_in);
    start_in      = 1'b1;
    accumulate_in = 1'b0;
    fill(8'd127, 8'd127, 8'd0);
    @(posedge clock_in);
    #1;
    start_in = 1'b0;
    wait_done(3, edges, busy_cycles);
    check("ign_latency", 32'(edges), 5);
    fill_exp(8'd11);
    check_mat("ign_d", d4);
    check("ign_ovf", 32'(ovf4), 0);

    // Reset at E2 of COMPUTE
    fill(8'd1, 8'd2, 8'd0);
    accumulate_in = 1'b0;
    start_run();
    @(posedge clock_in);
    #1;
    @(negedge clock_in);
    reset_in = 1'b1;
    @(posedge clock_in);
    #1;
    check("rst_mid_busy", 32'(busy4), 0);
    check("rst_mid_done", 32'(done4), 0);
    check("rst_mid_ovf", 32'(ovf4), 0);
    fill_exp(8'd0);
    check_mat("rst_mid_d", d4);
    // Reset beats a simultaneous start
    @(negedge clock_in);
    start_in = 1'b1;
    @(posedge clock_in);
    #1;
    check("rst_prio_busy", 32'(busy4), 0);
    @(negedge clock_in);
    start_in = 1'b0;
    reset_in = 1'b0;
    fill(8'd1, 8'd2, 8'd3);
    accumulate_in = 1'b1;
    start_run();
    wait_done(1, edges, busy_cycles);
    check("post_rst_latency", 32'(edges), 5);
    fill_exp(8'd11);
    check_mat("post_rst_d", d4);

    // LANES variants against the reference model: full range, then small range
    for (int set = 0; set < 2; set++) begin
      @(negedge clock_in);
      reset_in = 1'b1;
      @(negedge clock_in);
      reset_in = 1'b0;
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++) begin
          if (set == 0) begin
            a_m[i][j] = 8'($urandom);
            b_m[i][j] = 8'($urandom);
            c_m[i][j] = 8'($urandom);
          end else begin
            a_m[i][j] = 8'($urandom_range(15) - 8);
            b_m[i][j] = 8'($urandom_range(15) - 8);
            c_m[i][j] = 8'($urandom_range(15) - 8);
          end
        end
      accumulate_in = 1'b1;
      model();
      start_run();
      e4 = 0; e1 = 0; e16 = 0;
      for (int n = 1; n <= 40; n++) begin
        if (done4  && e4  == 0) e4  = n;
        if (done1  && e1  == 0) e1  = n;
        if (done16 && e16 == 0) e16 = n;
        @(posedge clock_in);
        #1;
      end
      check("lat_l4", 32'(e4), 5);
      check("lat_l1", 32'(e1), 17);
      check("lat_l16", 32'(e16), 2);
      check_mat("rand_l4", d4);
      check_mat("rand_l1", d1);
      check_mat("rand_l16", d16);
      check("rand_ovf_l4", 32'(ovf4), 32'(exp_ovf));
      check("rand_ovf_l1", 32'(ovf1), 32'(exp_ovf));
      check("rand_ovf_l16", 32'(ovf16), 32'(exp_ovf));
      check("rand_busy_l1", 32'(busy1), 0);
      check("rand_busy_l16", 32'(busy16), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tensor_core_mma_engine.md
# tensor_core_mma_engine

Parametrised successor to the small tensor core: a sequential DIM×DIM signed matrix-multiply-accumulate engine computing D = A·B (+ C) over LANES output elements per cycle. It sits beside the tensor-core register file, latches operands on a start handshake, and holds the results registered until the next start. It adds runtime accumulate mode, a sticky overflow flag, a compile-time saturation option, and synchronous reset, none of which the previous core has.

## Interface
- DATA_WIDTH, 8, operand/result element width (signed two's complement)
- DIM, 4, matrix dimension (square DIM×DIM)
- LANES, 4, output elements computed per cycle; must divide DIM*DIM (elaboration error otherwise)
- clock_in  input  1  sole clock, all state on rising edge
- reset_in  input  1  synchronous, active-high reset
- start_in  input  1  start request; sampled each rising edge
- accumulate_in  input  1  1: D = A·B + C; 0: D = A·B; latched with operands
- tensor_core_input1  input  [DATA_WIDTH-1:0] [DIM][DIM]  matrix A
- tensor_core_input2  input  [DATA_WIDTH-1:0] [DIM][DIM]  matrix B
- tensor_core_input3  input  [DATA_WIDTH-1:0] [DIM][DIM]  addend C
- tensor_core_output  output  [DATA_WIDTH-1:0] [DIM][DIM]  result D, registered
- busy_out  output  1  high in COMPUTE
- is_done_with_calculation  output  1  level, high in DONE
- overflow_out  output  1  sticky; set if any element of the current result did not fit DATA_WIDTH

## Operation
- FSM: IDLE → COMPUTE → DONE → (start) COMPUTE.
- Start accepted in IDLE or DONE only; start_in during COMPUTE ignored (no queueing).
- On accepted start: A, B, C and accumulate_in copied to internal operand registers; index ← 0; all tensor_core_output elements ← 0; overflow_out ← 0; done ← 0; busy ← 1. Inputs may change freely afterwards.
- Each COMPUTE cycle: for lane l in 0..LANES-1, flat index e = index + l, row = e / DIM, col = e % DIM; write D[row][col]; index ← index + LANES. Row-major order.
- Element arithmetic: products full 2*DATA_WIDTH signed; sum of DIM products plus sign-extended C (if accumulate latched) in ACC_WIDTH = 2*DATA_WIDTH + clog2(DIM) + 1; no intermediate truncation.
- Reduction to DATA_WIDTH per Configuration; overflow_out set when the ACC_WIDTH value is outside [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- Last group written when index = DIM*DIM - LANES; same edge: state ← DONE, done ← 1, busy ← 0. Results held until next accepted start or reset.

## Timing
- Start sampled at edge E0 → COMPUTE visible after E0; K = DIM*DIM/LANES compute edges E1..EK; done high after EK. Latency start-to-done: K+1 edges (default: 5).
- Element written at edge Ei visible on output immediately after Ei.
- Start in DONE: same as from IDLE; done drops after E0.
- Reset value of every output: tensor_core_output all 0, busy_out 0, is_done_with_calculation 0, overflow_out 0; state IDLE; index 0.
- Reset has priority over start on the same edge; reset mid-COMPUTE aborts, clears all outputs, returns to IDLE.

## Configuration
- TENSOR_CORE_SATURATE_EN defined: out-of-range results clamp to 2^(DATA_WIDTH-1)-1 or -2^(DATA_WIDTH-1).
- Undefined: results wrap (low DATA_WIDTH bits kept). overflow_out behaves identically in both builds.

## Structure
- Package tensor_core_pkg: state enum (IDLE, COMPUTE, DONE), ACC_WIDTH function/constant, clog2 helper, saturate/wrap reduction function.
- Sub-module tensor_core_dot_lane: combinational DIM-term signed dot product plus optional addend, ACC_WIDTH output, instantiated LANES times; top block owns FSM, operand registers, index, output registers, overflow.

## Test plan
- Defaults, A = identity, B[i][j] = 4i+j, accumulate 0 → D = B; done high exactly 5 edges after start sampled; busy high 4 cycles; overflow 0.
- A all 1, B all 2, C all 3, accumulate 1 → every D element 11; accumulate 0 same operands → 8.
- A all 127, B all 127 → sum 64516: with TENSOR_CORE_SATURATE_EN D = 127, without D = 4; overflow 1 both. A all -128, B all 127 → saturated -128 / wrapped 0; overflow 1.
- start_in pulsed at E2 of COMPUTE with different operands → ignored, results match first operands; start from DONE → new results, done low for 4 cycles.
- reset_in at E2 of COMPUTE → next cycle all outputs 0, IDLE; subsequent start completes correctly.
- LANES = 1 → done after 17 edges; LANES = 16 → done after 2 edges; identical D for identical random operands vs. reference model.
